muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_ctrl_div_step.sv | 22 ++
 rtl/muldiv_ctrl.sv | 143 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states,
// default iteration count and small two's-complement helpers.
package muldiv_pkg;

  localparam int DIV_ITER_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division step: shift {rem,quot} left, trial-subtract the
// divisor from the widened remainder and shift in the resulting quotient bit.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quot,
  input  logic [31:0] dvsr,
  output logic [31:0] rem_next,
  output logic [31:0] quot_next
);

  logic [32:0] shifted;
  logic [32:0] trial;
  logic        q_bit;

  // 33 bits: the shifted remainder can reach 2*dvsr-1, beyond 32 bits.
  assign shifted   = {rem, quot[31]};
  assign trial     = shifted - {1'b0, dvsr};
  assign q_bit     = ~trial[32];
  assign rem_next  = q_bit ? trial[31:0] : shifted[31:0];
  assign quot_next = {quot[30:0], q_bit};

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller: single-cycle registered
// multiply, iterative restoring divide, one-cycle HI/LO write strobe.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DIV_ITER = DIV_ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        cancel,
  output logic        stall_req,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

  state_t        state_reg, state_next;
  op_t           op_reg;
  logic [31:0]   srca_reg, srcb_reg, rem_reg, quot_reg, hi_reg, lo_reg;
  logic [CW-1:0] count_reg;

  logic          start_ok, last_iter, signed_div, busy_stall;
  logic [31:0]   dvsr, step_rem, step_quot, q_fix, r_fix;
  logic [63:0]   prod;

  assign start_ok   = startE & ~cancel;
  assign last_iter  = (count_reg == CW'(DIV_ITER - 1));
  assign signed_div = (op_reg == OP_DIV);
  assign dvsr       = signed_div ? abs32(srcb_reg) : srcb_reg;

  div_step u_div_step (
    .rem       (rem_reg),
    .quot      (quot_reg),
    .dvsr      (dvsr),
    .rem_next  (step_rem),
    .quot_next (step_quot)
  );

  // Quotient sign follows the operand signs; remainder follows the dividend.
  assign q_fix = (signed_div && (srca_reg[31] ^ srcb_reg[31])) ? neg32(step_quot) : step_quot;
  assign r_fix = (signed_div && srca_reg[31]) ? neg32(step_rem) : step_rem;

  // Extending both operands to 64 bits makes the low 64 product bits correct
  // for either signedness.
  always_comb begin
    logic sx;
    sx   = (op_reg == OP_MULT);
    prod = {{32{sx & srca_reg[31]}}, srca_reg} * {{32{sx & srcb_reg[31]}}, srcb_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy_stall = 1'b0;
    hilo_we    = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (start_ok) begin
          busy_stall = 1'b1;
          if (!opE[1])              state_next = S_MUL;
          else if (srcbE != 32'd0)  state_next = S_DIV;
          else                      state_next = S_DONE;
        end
      end
      S_MUL: begin
        busy_stall = 1'b1;
        state_next = cancel ? S_IDLE : S_DONE;
      end
      S_DIV: begin
        busy_stall = 1'b1;
        if (cancel)         state_next = S_IDLE;
        else if (last_iter) state_next = S_DONE;
      end
      S_DONE: begin
        hilo_we    = ~cancel;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign stall_req = busy_stall & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg    <= OP_MULT;
      srca_reg  <= '0;
      srcb_reg  <= '0;
      rem_reg   <= '0;
      quot_reg  <= '0;
      count_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_ok) begin
            op_reg    <= op_t'(opE);
            srca_reg  <= srcaE;
            srcb_reg  <= srcbE;
            rem_reg   <= '0;
            quot_reg  <= (op_t'(opE) == OP_DIV) ? abs32(srcaE) : srcaE;
            count_reg <= '0;
            if (opE[1] && srcbE == 32'd0) begin
              hi_reg <= srcaE;
              lo_reg <= 32'hFFFF_FFFF;
            end
          end
        end
        S_MUL: begin
          if (!cancel) {hi_reg, lo_reg} <= prod;
        end
        S_DIV: begin
          if (!cancel) begin
            rem_reg  <= step_rem;
            quot_reg <= step_quot;
            if (last_iter) begin
              hi_reg <= r_fix;
              lo_reg <= q_fix;
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised self-checking bench for muldiv_ctrl against a plain-arithmetic
// model of HI/LO results and start-to-strobe latency.
module tb_muldiv_ctrl;

  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE, srcbE;
  logic        cancel;
  logic        stall_req, hilo_we;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] last_hi, last_lo;

  muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .startE    (startE),
    .opE       (opE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .cancel    (cancel),
    .stall_req (stall_req),
    .hilo_we   (hilo_we),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definition of each op.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo, output int lat);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin p = 64'(sa * sb); {ehi, elo} = p; lat = 2; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; {ehi, elo} = p; lat = 2; end
      default: begin
        if (b == 32'd0) begin
          ehi = a; elo = 32'hFFFF_FFFF; lat = 1;
        end else if (op == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          elo = sq[31:0]; ehi = sr[31:0]; lat = DIV_LAT;
        end else begin
          elo = a / b; ehi = a % b; lat = DIV_LAT;
        end
      end
    endcase
  endtask

  // Issue one op at a negedge (cycle 0) and follow it to its hilo_we strobe.
  // With noise set, startE is kept busy with junk while the unit is working.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit noise);
    logic [31:0] ehi, elo, ghi, glo;
    int          lat, got_lat;
    model(op, a, b, ehi, elo, lat);
    @(negedge clk);
    startE = 1'b1; opE = op; srcaE = a; srcbE = b; cancel = 1'b0;
    #1 check({name, " stall_c0"}, 64'(stall_req), 64'd1);
    got_lat = -1;
    ghi = '0; glo = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (hilo_we) begin
        got_lat = cyc; ghi = hi_o; glo = lo_o;
        check({name, " stall_done"}, 64'(stall_req), 64'd0);
        break;
      end
      if (stall_req !== 1'b1) check({name, " stall_busy"}, 64'(stall_req), 64'd1);
      startE = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      opE = 2'($urandom); srcaE = $urandom; srcbE = $urandom;
    end
    startE = 1'b0;
    check({name, " latency"}, 64'(got_lat), 64'(lat));
    check({name, " hi"}, 64'(ghi), 64'(ehi));
    check({name, " lo"}, 64'(glo), 64'(elo));
    $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h lat=%0d", op, a, b, ghi, glo, got_lat);
    last_hi = ehi; last_lo = elo;
  endtask

  task automatic watch_no_we(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (hilo_we) seen++;
    end
    check({name, " no_we"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);
    check("reset we", 64'(hilo_we), 64'd0);
    check("reset stall", 64'(stall_req), 64'd0);
    rst = 1'b0;

    do_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
    do_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    do_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op("divu0", 2'b11, 32'h1234, 32'd0, 1'b0);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("div0", 2'b10, 32'h8000_0001, 32'd0, 1'b0);

    @(negedge clk);
    check("hold hi", 64'(hi_o), 64'(last_hi));
    check("hold lo", 64'(lo_o), 64'(last_lo));
    check("hold we", 64'(hilo_we), 64'd0);

    // Cancel wins over start in IDLE.
    startE = 1'b1; opE = 2'b11; srcaE = 32'd100; srcbE = 32'd7; cancel = 1'b1;
    #1 check("cancel_idle stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    startE = 1'b0; cancel = 1'b0;
    #1 check("cancel_idle stall2", 64'(stall_req), 64'd0);
    watch_no_we("cancel_idle", 40);

    // Cancel mid-divide at cycle 10.
    startE = 1'b1; opE = 2'b11; srcaE = 32'd100; srcbE = 32'd7;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      startE = 1'b0;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1 check("cancel_div stall", 64'(stall_req), 64'd0);
    watch_no_we("cancel_div", 40);
    do_op("divu_after_cancel", 2'b11, 32'd100, 32'd7, 1'b0);

    // Cancel in DONE suppresses the strobe.
    @(negedge clk);
    startE = 1'b1; opE = 2'b01; srcaE = 32'd5; srcbE = 32'd6;
    @(negedge clk);
    startE = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    #1 check("cancel_done we", 64'(hilo_we), 64'd0);
    @(negedge clk);
    cancel = 1'b0;
    watch_no_we("cancel_done", 5);

    // Reset mid-divide at cycle 5.
    startE = 1'b1; opE = 2'b10; srcaE = 32'hFFFF_FF00; srcbE = 32'd3;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      startE = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rst_mid hi", 64'(hi_o), 64'd0);
    check("rst_mid lo", 64'(lo_o), 64'd0);
    check("rst_mid stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_we("rst_mid", 40);

    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      do_op("rand", rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
